alb_op_sequencer: RTL and testbench

- Control/datapath stage wrapped around the team's 4-bit ALB (MR/MS/CI/ALB_MI in; F_ALB/CO/VO/NO/ZO out).
- Holds an 8-bit register file and accepts commands over a valid/ready handshake.
- Runs each 8-bit operation as two chained 4-bit ALB passes: low nibble, then high nibble, with CO fed into CI.
- Writes the result back, updates a persistent flag register, and pulses a response.

---
 rtl/alb_op_sequencer.sv | 136 +++++++++++++
 tb/tb_alb_op_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alb_op_sequencer.sv
// Runs 8-bit ops as two chained 4-bit passes (low, then high nibble) through an external ALB; owns regfile and flags.
// Latency: accept in cycle N -> rsp_valid in N+3 (N+1 for a trapped reserved op when ALB_SEQ_ILLEGAL_TRAP_EN is defined).
// Backpressure: cmd_ready only in IDLE, commands are never queued; ALB_SEQ_ILLEGAL_TRAP_EN adds rsp_err and traps ops 1xx.
module alb_op_sequencer #(
    parameter  int NREG = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_src_a,
    input  logic [AW-1:0] cmd_src_b,
    input  logic [AW-1:0] cmd_dst,
    input  logic          cmd_ci,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic [3:0]    alb_mr,
    output logic [3:0]    alb_ms,
    output logic          alb_ci,
    output logic [2:0]    alb_mi,
    input  logic [3:0]    alb_f,
    input  logic          alb_co,
    input  logic          alb_vo,
    input  logic          alb_no,
    input  logic          alb_zo,
    output logic          rsp_valid,
    output logic [7:0]    rsp_data,
    output logic [3:0]    flags_q
`ifdef ALB_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic          rsp_err
`endif
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [2:0] OP_SUB   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] ALB_IDLE = 3'b111;

    state_t        state;
    logic [7:0]    regs [NREG];
    logic [AW-1:0] dst_q;
    logic          addsub_q;
    logic [3:0]    a_hi;
    logic [3:0]    b_hi;
    logic [3:0]    res_lo;
    logic          z_lo;

    logic [7:0]    src_a;
    logic [7:0]    src_b;
    logic          cmd_addsub;

    // Operands are read before this cycle's load lands, so a same-cycle load is not seen.
    assign src_a      = regs[cmd_src_a];
    assign src_b      = regs[cmd_src_b];
    assign cmd_addsub = (cmd_op == OP_SUB) || (cmd_op == OP_ADD);
    assign cmd_ready  = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
            dst_q     <= '0;
            addsub_q  <= 1'b0;
            a_hi      <= 4'h0;
            b_hi      <= 4'h0;
            res_lo    <= 4'h0;
            z_lo      <= 1'b0;
            alb_mr    <= 4'h0;
            alb_ms    <= 4'h0;
            alb_ci    <= 1'b0;
            alb_mi    <= ALB_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            flags_q   <= 4'h0;
`ifdef ALB_SEQ_ILLEGAL_TRAP_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef ALB_SEQ_ILLEGAL_TRAP_EN
            rsp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dst_q    <= cmd_dst;
                        addsub_q <= cmd_addsub;
                        a_hi     <= src_a[7:4];
                        b_hi     <= src_b[7:4];
`ifdef ALB_SEQ_ILLEGAL_TRAP_EN
                        if (cmd_op[2]) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 8'h00;
                            rsp_err   <= 1'b1;
                        end else
`endif
                        begin
                            state  <= LO;
                            alb_mr <= src_a[3:0];
                            alb_ms <= src_b[3:0];
                            alb_ci <= cmd_addsub & cmd_ci;
                            alb_mi <= cmd_op;
                        end
                    end
                end
                LO: begin
                    res_lo <= alb_f;
                    z_lo   <= alb_zo;
                    alb_mr <= a_hi;
                    alb_ms <= b_hi;
                    alb_ci <= addsub_q & alb_co;
                    state  <= HI;
                end
                HI: begin
                    regs[dst_q] <= {alb_f, res_lo};
                    flags_q     <= {alb_co, alb_vo, alb_no, alb_zo & z_lo};
                    rsp_valid   <= 1'b1;
                    rsp_data    <= {alb_f, res_lo};
                    alb_mr      <= 4'h0;
                    alb_ms      <= 4'h0;
                    alb_ci      <= 1'b0;
                    alb_mi      <= ALB_IDLE;
                    state       <= DONE;
                end
                default: state <= IDLE;
            endcase
            // Placed after the writeback so a load to the same register wins.
            if (ld_en) regs[ld_addr] <= ld_data;
        end
    end
endmodule

// File: tb/tb_alb_op_sequencer.sv
// Bench for alb_op_sequencer: behavioural 4-bit ALB, 8-bit reference model and scoreboard monitor.
// Builds with or without ALB_SEQ_ILLEGAL_TRAP_EN.
module tb_alb_op_sequencer;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'b000;
    logic [AW-1:0] cmd_src_a = '0;
    logic [AW-1:0] cmd_src_b = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic          cmd_ci = 1'b0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = 8'h00;
    logic [3:0]    alb_mr, alb_ms, alb_f;
    logic          alb_ci, alb_co, alb_vo, alb_no, alb_zo;
    logic [2:0]    alb_mi;
    logic          rsp_valid;
    logic [7:0]    rsp_data;
    logic [3:0]    flags_q;
`ifdef ALB_SEQ_ILLEGAL_TRAP_EN
    logic          rsp_err;
`endif

    always #5 clk = ~clk;

    alb_op_sequencer #(.NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_ci(cmd_ci),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alb_mr(alb_mr), .alb_ms(alb_ms), .alb_ci(alb_ci), .alb_mi(alb_mi),
        .alb_f(alb_f), .alb_co(alb_co), .alb_vo(alb_vo), .alb_no(alb_no), .alb_zo(alb_zo),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flags_q(flags_q)
`ifdef ALB_SEQ_ILLEGAL_TRAP_EN
        , .rsp_err(rsp_err)
`endif
    );

    // 4-bit ALB: SUB = A + ~B + CI, ADD = A + B + CI; logic ops and reserved codes give C = V = 0.
    logic [3:0] alb_opb;
    logic [4:0] alb_sum;
    always_comb begin
        alb_opb = (alb_mi == 3'b000) ? ~alb_ms : alb_ms;
        alb_sum = {1'b0, alb_mr} + {1'b0, alb_opb} + {4'h0, alb_ci};
        alb_f   = 4'h0;
        alb_co  = 1'b0;
        alb_vo  = 1'b0;
        case (alb_mi)
            3'b000, 3'b011: begin
                alb_f  = alb_sum[3:0];
                alb_co = alb_sum[4];
                alb_vo = (alb_mr[3] == alb_opb[3]) && (alb_sum[3] != alb_mr[3]);
            end
            3'b001: alb_f = alb_mr & alb_ms;
            3'b010: alb_f = alb_mr | alb_ms;
            default: alb_f = 4'h0;
        endcase
        alb_no = alb_f[3];
        alb_zo = (alb_f == 4'h0);
    end

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Whole-byte reference: C is the 8-bit carry out, V the signed 8-bit overflow.
    function automatic void ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic ci, output logic [7:0] r, output logic [3:0] fl);
        int u, s;
        logic c, v;
        u = 0; s = 0; c = 1'b0; v = 1'b0;
        case (op)
            3'b011: begin
                u = int'(a) + int'(b) + int'(ci);
                s = int'($signed(a)) + int'($signed(b)) + int'(ci);
            end
            3'b000: begin
                u = int'(a) + (255 - int'(b)) + int'(ci);
                s = int'($signed(a)) - int'($signed(b)) - 1 + int'(ci);
            end
            3'b001: u = int'(a & b);
            3'b010: u = int'(a | b);
            default: u = 0;
        endcase
        r = u[7:0];
        if (op == 3'b000 || op == 3'b011) begin
            c = (u > 255);
            v = (s > 127) || (s < -128);
        end
        fl = {c, v, r[7], (r == 8'h00)};
    endfunction

    typedef struct { logic [7:0] data; logic err; int due; } exp_t;
    exp_t expq[$];

    logic [7:0]    mregs [NREG];
    logic [3:0]    mflags;
    int            cyc, idle_from, wb_cyc, inf_k;
    bit            wb_pend, inf_vld;
    logic [AW-1:0] wb_dst;
    logic [7:0]    wb_data, inf_a, inf_b;
    logic [3:0]    wb_flags;
    logic [2:0]    inf_op;
    logic          inf_ci;

    // Reference model: tracks registers, flags and expected responses at every rising edge.
    initial begin : model
        exp_t e;
        logic [7:0] r;
        logic [3:0] fl;
        bit trap;
        cyc = 0; idle_from = 0; wb_pend = 0; inf_vld = 0; mflags = 4'h0;
        for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
                mflags = 4'h0; wb_pend = 0; inf_vld = 0; idle_from = 0;
                expq.delete();
                continue;
            end
            if (wb_pend && cyc == wb_cyc) begin
                mregs[wb_dst] = wb_data;
                mflags = wb_flags;
                wb_pend = 0;
            end
            if (cmd_valid && cmd_ready) begin
                ref_op(cmd_op, mregs[cmd_src_a], mregs[cmd_src_b], cmd_ci, r, fl);
                trap = 0;
`ifdef ALB_SEQ_ILLEGAL_TRAP_EN
                trap = cmd_op[2];
`endif
                if (trap) begin
                    e.data = 8'h00; e.err = 1'b1; e.due = cyc; idle_from = cyc + 1;
                end else begin
                    e.data = r; e.err = 1'b0; e.due = cyc + 2; idle_from = cyc + 3;
                    wb_pend = 1; wb_cyc = cyc + 2; wb_dst = cmd_dst; wb_data = r; wb_flags = fl;
                    inf_vld = 1; inf_k = cyc; inf_op = cmd_op;
                    inf_a = mregs[cmd_src_a]; inf_b = mregs[cmd_src_b]; inf_ci = cmd_ci;
                end
                expq.push_back(e);
            end
            if (ld_en) mregs[ld_addr] = ld_data;
        end
    end

    // Monitor: checks handshake, ALB drive and flags every cycle, pops the scoreboard on rsp_valid.
    initial begin : monitor
        exp_t e;
        logic [11:0] drv_exp;
        bit addsub;
        int lo;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            chk("cmd_ready", cmd_ready, cyc >= idle_from);
            chk("flags_q", flags_q, mflags);
            drv_exp = {4'h0, 4'h0, 1'b0, 3'b111};
            addsub = inf_vld && (inf_op == 3'b000 || inf_op == 3'b011);
            if (inf_vld && cyc == inf_k) begin
                drv_exp = {inf_a[3:0], inf_b[3:0], addsub & inf_ci, inf_op};
            end else if (inf_vld && cyc == inf_k + 1) begin
                lo = int'(inf_a[3:0]) + ((inf_op == 3'b000) ? 15 - int'(inf_b[3:0]) : int'(inf_b[3:0])) + int'(inf_ci);
                drv_exp = {inf_a[7:4], inf_b[7:4], addsub & (lo > 15), inf_op};
            end
            chk("alb_drive", {alb_mr, alb_ms, alb_ci, alb_mi}, drv_exp);
            if (rsp_valid) begin
                if (expq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rsp_unexpected: got rsp_data %0h, expected no response (t=%0t)", rsp_data, $time);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_cycle", cyc, e.due);
                    chk("rsp_data", rsp_data, e.data);
`ifdef ALB_SEQ_ILLEGAL_TRAP_EN
                    chk("rsp_err", rsp_err, e.err);
`endif
                end
            end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                e = expq.pop_front();
                n_vec++; n_err++;
                $display("FAIL rsp_missing: got no rsp_valid, expected data %0h at cycle %0d", e.data, e.due);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a[AW-1:0]; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Holds cmd_valid until accepted; the optional load is driven in the accept cycle.
    task automatic send(input logic [2:0] op, input int sa, input int sb, input int d, input logic ci,
                        input bit le, input int la, input logic [7:0] ld);
        int n;
        cmd_op = op; cmd_src_a = sa[AW-1:0]; cmd_src_b = sb[AW-1:0]; cmd_dst = d[AW-1:0];
        cmd_ci = ci; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: got cmd_ready 0 for 40 cycles, expected 1");
        end
        if (le) begin
            ld_en = 1'b1; ld_addr = la[AW-1:0]; ld_data = ld;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; ld_en = 1'b0;
    endtask

    initial begin : stim
        logic [2:0] op;
        int r, n;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_flags", flags_q, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alb_mi", alb_mi, 3'b111);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        load(0, 8'h3C); load(1, 8'h1F);
        send(3'b011, 0, 1, 2, 1'b0, 0, 0, 8'h00);
        send(3'b010, 2, 2, 3, 1'b0, 0, 0, 8'h00);
        load(0, 8'h10); load(1, 8'h01);
        send(3'b000, 0, 1, 2, 1'b1, 0, 0, 8'h00);
        load(0, 8'hFF); load(1, 8'h01);
        send(3'b011, 0, 1, 2, 1'b0, 0, 0, 8'h00);
        load(0, 8'h7F);
        send(3'b011, 0, 1, 3, 1'b0, 0, 0, 8'h00);
        load(0, 8'hF0); load(1, 8'h3C);
        send(3'b001, 0, 1, 2, 1'b1, 0, 0, 8'h00);
        send(3'b001, 0, 1, 3, 1'b0, 0, 0, 8'h00);

        load(1, 8'h55);
        send(3'b010, 1, 1, 2, 1'b0, 1, 1, 8'hAA);
        send(3'b010, 1, 1, 3, 1'b0, 0, 0, 8'h00);
        send(3'b011, 0, 1, 2, 1'b0, 0, 0, 8'h00);
        idle(1);
        load(2, 8'h5A);
        send(3'b010, 2, 2, 3, 1'b0, 0, 0, 8'h00);

        load(0, 8'h21); load(1, 8'h34);
        send(3'b101, 0, 1, 2, 1'b1, 0, 0, 8'h00);
        send(3'b010, 2, 2, 3, 1'b0, 0, 0, 8'h00);

        send(3'b011, 0, 1, 1, 1'b0, 0, 0, 8'h00);
        idle(1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("post_rst_rsp_data", rsp_data, 0);
        chk("post_rst_flags", flags_q, 0);
        send(3'b010, 1, 1, 2, 1'b0, 0, 0, 8'h00);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 2) == 0) load($urandom_range(0, NREG - 1), 8'($urandom));
            r = $urandom_range(0, 9);
            op = (r == 9) ? 3'($urandom_range(4, 7)) : 3'(r % 4);
            send(op, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                 1'($urandom), ($urandom_range(0, 4) == 0), $urandom_range(0, NREG - 1), 8'($urandom));
            repeat ($urandom_range(0, 4)) begin
                if ($urandom_range(0, 1) == 1) load($urandom_range(0, NREG - 1), 8'($urandom));
                else idle(1);
            end
        end

        n = 0;
        while (expq.size() > 0 && n < 20) begin
            idle(1);
            n++;
        end
        if (expq.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", expq.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
